instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Drives the instruction-memory read side and supplies the instruction register's write interface (mem_data, IRwrite) in the multi-cycle RV32I core.
- Owns the PC and issues a req/ack read to a variable-latency instruction memory.
- On ack, presents the fetched word with a one-cycle IRwrite strobe and advances the PC by 4.
- Flags misaligned PCs and memory timeouts with a sticky fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 15, max cycles in REQ without mem_ack before fault (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-low
fetch_start  input  1  control FSM request to fetch at current PC
pc_load  input  1  load pc_next into PC (branch/jump)
pc_next  input  32  new PC value
fault_clr  input  1  clears fault, returns to IDLE
mem_req  output  1  read request to instruction memory
mem_addr  output  32  read address, word-aligned
mem_ack  input  1  memory read data valid
mem_rdata  input  32  memory read data
mem_data  output  32  fetched word to instruction register
IRwrite  output  1  one-cycle instruction-register write strobe
pc  output  32  current PC
busy  output  1  fetch in progress (state != IDLE)
fault  output  1  sticky: misaligned PC or timeout

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC; mem_req=0, mem_addr=0, mem_data=0, IRwrite=0, fault=0.
  - Timeout counter=0; state=IDLE.
- States: IDLE, REQ, DONE, ERR. busy=1 in REQ/DONE/ERR. All outputs are registered.
- IDLE:
  - pc_load=1: pc<=pc_next.
  - fetch_start=1: the target is pc_next if pc_load is also 1, else pc.
    - Target[1:0]!=0: fault<=1, go to ERR; no request is issued.
    - Target aligned: mem_addr<=target, mem_req<=1, counter<=0, go to REQ.
- REQ:
  - mem_req stays 1 and mem_addr holds stable until ack or timeout.
  - mem_ack=1: mem_data<=mem_rdata, IRwrite<=1, mem_req<=0, pc<=mem_addr+4 (mod 2^32, wraps), go to DONE.
  - No ack: counter increments. When counter==TIMEOUT-1 without ack: mem_req<=0, fault<=1, go to ERR.
  - An ack in the same cycle as the timeout wins; the fetch completes normally.
- DONE:
  - IRwrite<=0, go to IDLE. IRwrite is high for exactly one cycle.
  - mem_data holds its value until the next ack.
- ERR:
  - fault holds 1 and mem_req stays 0.
  - fault_clr=1: fault<=0, go to IDLE. pc is unchanged, so the next fetch retries.
- Ignored events:
  - fetch_start and pc_load outside IDLE are ignored (the control FSM must wait for busy=0).
  - mem_ack outside REQ is ignored.
  - fault_clr outside ERR is ignored.
- Latency:
  - fetch_start in cycle 0 gives mem_req=1 in cycle 1.
  - An ack in cycle k (k>=1) gives IRwrite=1, mem_data and pc updated in cycle k+1, and busy=0 in cycle k+2.
  - Minimum fetch is 3 cycles from start to idle.
- Reset mid-fetch: all state returns to reset values immediately. mem_req drops asynchronously; a pending ack after reset is ignored.
- Counter width: $clog2(TIMEOUT+1) bits, saturating, never wraps.

Decomposition:
- Shared package (core_pkg): fetch state enum (IDLE/REQ/DONE/ERR), XLEN=32, INSTR_BYTES=4 constant.
- Sub-module: fetch_timeout_ctr, a clear/enable saturating counter with an expired output parameterised by TIMEOUT. It is reusable for data-memory access.
- The FSM, PC register and output registers stay in instr_fetch_unit.

Test Plan:
- Reset then single fetch: rst low→high, fetch_start 1 cycle, memory acks on its 1st REQ cycle with 32'h00500093 → mem_addr=0; IRwrite pulses exactly 1 cycle with mem_data=32'h00500093; pc=4; busy drops 2 cycles after ack.
- Wait states: ack delayed 5 cycles, rdata=32'hDEADBEEF → mem_req and mem_addr=4 stable for all 5 cycles; one IRwrite pulse; pc=8.
- Branch plus fetch same cycle: pc_load=1, pc_next=32'h0000_0100, fetch_start=1 → mem_addr=32'h100; after ack pc=32'h104.
- Misaligned: pc_load pc_next=32'h102, then fetch_start → mem_req never asserts; fault=1; fault_clr returns to IDLE with pc=32'h102 and fault=0.
- Timeout (TIMEOUT=15): no ack → mem_req high for exactly 15 cycles then 0; fault=1; pc unchanged; no IRwrite. Ack coinciding with the last cycle completes normally instead.
- Reset mid-REQ and wrap: assert rst during REQ → mem_req=0, pc=RESET_PC immediately, late ack ignored. Then set pc_next=32'hFFFF_FFFC and fetch with ack → pc wraps to 32'h0000_0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, datapath width, instruction size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    // A fetch address is legal only on a 4-byte boundary.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait-cycle counter with clear/enable and an expired flag.
// Latency: count updates one cycle after clr/en; expired is a decode of count.
// Backpressure: none; holds at TIMEOUT once reached, never wraps.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // Clear has priority; increment stops at TIMEOUT so the count cannot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != W'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    // Expired on the last allowed wait cycle (count TIMEOUT-1).
    assign expired = (count >= W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC, issues req/ack reads, strobes IRwrite on return.
// Latency: start->mem_req 1 cycle; ack->IRwrite 1 cycle; ack->idle 2 cycles.
// Backpressure: waits on mem_ack up to TIMEOUT cycles; new starts ignored while busy.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic        fault_clr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_data,
    output logic        IRwrite,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fault
);

    fetch_state_t state, state_nxt;

    logic [XLEN-1:0] pc_nxt, addr_nxt, data_nxt, target;
    logic            req_nxt, irw_nxt, fault_nxt;
    logic            ctr_clr, ctr_en, ctr_expired;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        addr_nxt  = mem_addr;
        data_nxt  = mem_data;
        req_nxt   = mem_req;
        irw_nxt   = 1'b0;
        fault_nxt = fault;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        target    = pc_load ? pc_next : pc;

        unique case (state)
            IDLE: begin
                if (pc_load) begin
                    pc_nxt = pc_next;
                end
                if (fetch_start) begin
                    if (!is_aligned(target)) begin
                        fault_nxt = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        addr_nxt  = target;
                        req_nxt   = 1'b1;
                        ctr_clr   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still completes the fetch.
                if (mem_ack) begin
                    data_nxt  = mem_rdata;
                    irw_nxt   = 1'b1;
                    req_nxt   = 1'b0;
                    pc_nxt    = mem_addr + XLEN'(INSTR_BYTES);
                    state_nxt = DONE;
                end else if (ctr_expired) begin
                    req_nxt   = 1'b0;
                    fault_nxt = 1'b1;
                    state_nxt = ERR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                // PC is left untouched so the next fetch retries the same address.
                if (fault_clr) begin
                    fault_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and PC registers; busy tracks the registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            IRwrite  <= 1'b0;
            fault    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
            mem_data <= data_nxt;
            IRwrite  <= irw_nxt;
            fault    <= fault_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_fetch_unit;

    localparam int          TO    = 15;
    localparam logic [31:0] RSTPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_next = '0;
    logic        fault_clr = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, IRwrite, busy, fault;
    logic [31:0] mem_addr, mem_data, pc;

    int total = 0;
    int bad   = 0;
    int req_cycles = 0;
    int irw_pulses = 0;

    instr_fetch_unit #(
        .RESET_PC (RSTPC),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .fault_clr   (fault_clr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_data    (mem_data),
        .IRwrite     (IRwrite),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Reference model: a fetch is "waiting" for up to TO cycles, then either
    // delivers a word (one strobe cycle) or parks in a fault until cleared.
    logic        m_req, m_irw, m_fault, m_busy;
    logic [31:0] m_addr, m_data, m_pc, m_tgt;
    int          m_waited;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req = 0; m_irw = 0; m_fault = 0; m_busy = 0;
            m_addr = 0; m_data = 0; m_pc = RSTPC; m_waited = 0;
        end else if (m_irw) begin
            m_irw  = 0;
            m_busy = 0;
        end else if (m_req) begin
            if (mem_ack) begin
                m_data = mem_rdata;
                m_irw  = 1;
                m_req  = 0;
                m_pc   = m_addr + 32'd4;
            end else if (m_waited + 1 == TO) begin
                m_req   = 0;
                m_fault = 1;
            end else begin
                m_waited++;
            end
        end else if (m_fault) begin
            if (fault_clr) begin
                m_fault = 0;
                m_busy  = 0;
            end
        end else begin
            m_tgt = pc_load ? pc_next : m_pc;
            if (pc_load) m_pc = pc_next;
            if (fetch_start) begin
                m_busy = 1;
                if ((m_tgt % 4) != 0) begin
                    m_fault = 1;
                end else begin
                    m_req    = 1;
                    m_addr   = m_tgt;
                    m_waited = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("mdl_req",   32'(mem_req), 32'(m_req));
            chk("mdl_irw",   32'(IRwrite), 32'(m_irw));
            chk("mdl_fault", 32'(fault),   32'(m_fault));
            chk("mdl_busy",  32'(busy),    32'(m_busy));
            chk("mdl_pc",    pc,           m_pc);
            chk("mdl_data",  mem_data,     m_data);
            if (mem_req) chk("mdl_addr", mem_addr, m_addr);
            if (mem_req) req_cycles++;
            if (IRwrite) irw_pulses++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the request for n cycles (checking address stability), then ack.
    task automatic ack_after(input int n, input logic [31:0] exp_addr, input logic [31:0] data);
        for (int i = 0; i < n; i++) begin
            chk("wait_req",  32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, exp_addr);
            tick();
        end
        chk("ack_req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack = 1'b0;
    endtask

    int r0, p0;

    initial begin
        fork
            compare_loop();
        join_none

        tick(); tick();
        chk("rst_pc",    pc,       32'h0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_data",  mem_data, 32'h0);
        chk("rst_irw",   32'(IRwrite), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch, ack on first request cycle.
        p0 = irw_pulses;
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        chk("t1_addr", mem_addr, 32'h0);
        ack_after(0, 32'h0, 32'h0050_0093);
        chk("t1_irw",  32'(IRwrite), 32'd1);
        chk("t1_data", mem_data, 32'h0050_0093);
        chk("t1_pc",   pc, 32'h4);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_irw_low", 32'(IRwrite), 32'd0);
        chk("t1_idle",    32'(busy), 32'd0);
        chk("t1_pulses",  32'(irw_pulses - p0), 32'd1);

        // Five wait states.
        p0 = irw_pulses; r0 = req_cycles;
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        ack_after(5, 32'h4, 32'hDEAD_BEEF);
        chk("t2_data", mem_data, 32'hDEAD_BEEF);
        chk("t2_pc",   pc, 32'h8);
        tick();
        chk("t2_pulses", 32'(irw_pulses - p0), 32'd1);
        chk("t2_reqcyc", 32'(req_cycles - r0), 32'd6);

        // Branch and fetch in the same cycle.
        pc_load = 1'b1; pc_next = 32'h100; fetch_start = 1'b1;
        tick();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("t3_addr", mem_addr, 32'h100);
        ack_after(0, 32'h100, 32'h0000_0013);
        chk("t3_pc", pc, 32'h104);
        tick();

        // Misaligned target.
        r0 = req_cycles;
        pc_load = 1'b1; pc_next = 32'h102; tick(); pc_load = 1'b0;
        chk("t4_pc_load", pc, 32'h102);
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_busy",  32'(busy), 32'd1);
        tick(); tick(); tick();
        chk("t4_noreq", 32'(req_cycles - r0), 32'd0);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        chk("t4_clr",  32'(fault), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_pc",   pc, 32'h102);

        // Timeout with no ack.
        pc_load = 1'b1; pc_next = 32'h200; tick(); pc_load = 1'b0;
        p0 = irw_pulses; r0 = req_cycles;
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_reqcyc", 32'(req_cycles - r0), 32'd15);
        chk("t5_fault",  32'(fault), 32'd1);
        chk("t5_pc",     pc, 32'h200);
        chk("t5_noirw",  32'(irw_pulses - p0), 32'd0);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;

        // Ack on the last allowed cycle completes normally.
        r0 = req_cycles;
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        ack_after(14, 32'h200, 32'hCAFE_0001);
        chk("t5b_irw",    32'(IRwrite), 32'd1);
        chk("t5b_fault",  32'(fault), 32'd0);
        chk("t5b_pc",     pc, 32'h204);
        chk("t5b_data",   mem_data, 32'hCAFE_0001);
        chk("t5b_reqcyc", 32'(req_cycles - r0), 32'd15);
        tick();

        // Reset in the middle of a request; a late ack must be ignored.
        fetch_start = 1'b1; tick(); fetch_start = 1'b0;
        tick();
        chk("t6_inreq", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_req_async", 32'(mem_req), 32'd0);
        chk("t6_pc_async",  pc, RSTPC);
        chk("t6_busy",      32'(busy), 32'd0);
        #1;
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        chk("t6_late_irw",  32'(IRwrite), 32'd0);
        chk("t6_late_data", mem_data, 32'h0);
        chk("t6_late_pc",   pc, RSTPC);

        // PC wrap at the top of the address space.
        pc_load = 1'b1; pc_next = 32'hFFFF_FFFC; fetch_start = 1'b1;
        tick();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("t7_addr", mem_addr, 32'hFFFF_FFFC);
        ack_after(2, 32'hFFFF_FFFC, 32'h0000_0011);
        chk("t7_wrap", pc, 32'h0);
        for (int i = 0; i < 8 && busy; i++) tick();
        chk("t7_idle", 32'(busy), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
